// File: rtl/cacheline_burst_adapter_pkg.sv
// Shared types and constants for the cache-line to memory-burst adapter.
package cla_types;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    RESP
  } cla_state_e;

  localparam int BURST_WIDTH = 64;
  localparam int LINE_WIDTH  = 256;
  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int BEAT_IDX_W  = $clog2(BEATS);

  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT   = BEAT_IDX_W'(BEATS - 1);
  localparam logic [7:0]            TIMEOUT_MAX = 8'd255;

endpackage

// File: rtl/cacheline_burst_adapter_line_buffer.sv
// Line-wide register: whole-line load for writebacks, per-beat load for fills,
// and a beat-select read port feeding the write data path.
module cla_line_buffer
  import cla_types::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_line_i,
  input  logic [LINE_WIDTH-1:0] line_i,
  input  logic                  ld_beat_i,
  input  logic [BEAT_IDX_W-1:0] wr_idx_i,
  input  logic [BURST_WIDTH-1:0] beat_i,
  input  logic [BEAT_IDX_W-1:0] rd_idx_i,
  output logic [BURST_WIDTH-1:0] beat_o,
  output logic [LINE_WIDTH-1:0] line_o
);

  logic [LINE_WIDTH-1:0] line_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else if (ld_line_i) begin
      line_q <= line_i;
    end else if (ld_beat_i) begin
      line_q[wr_idx_i*BURST_WIDTH +: BURST_WIDTH] <= beat_i;
    end
  end

  assign beat_o = line_q[rd_idx_i*BURST_WIDTH +: BURST_WIDTH];
  assign line_o = line_q;

endmodule

// File: rtl/cacheline_burst_adapter.sv
// Splits cache line fills/writebacks into 4-beat memory bursts; all outputs registered.
// Optional burst watchdog with sticky err_o is enabled by defining CLA_TIMEOUT_EN.
module cacheline_burst_adapter
  import cla_types::*;
#(
  parameter int s_offset    = 5,
  parameter int burst_width = BURST_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  output logic                   resp_o,
  output logic [31:0]            address_o,
  output logic                   read_o,
  output logic                   write_o,
  output logic [burst_width-1:0] burst_o,
  input  logic [burst_width-1:0] burst_i,
  input  logic                   resp_i,
  output logic                   err_o
);

  localparam logic [31:0] ADDR_MASK = ~((32'd1 << s_offset) - 32'd1);

  cla_state_e             state_q, state_d;
  logic [BEAT_IDX_W-1:0]  cnt_q, cnt_d;
  logic [31:0]            addr_q, addr_d;
  logic [burst_width-1:0] burst_q, burst_d;
  logic [LINE_WIDTH-1:0]  fill_q, fill_d;
  logic                   read_q, write_q, resp_q;
  logic                   ld_line, ld_beat;
  logic [burst_width-1:0] buf_beat;
  logic [LINE_WIDTH-1:0]  buf_line;
`ifdef CLA_TIMEOUT_EN
  logic [7:0]             wdog_q, wdog_d;
  logic                   err_q, err_d;
`endif

  cla_line_buffer u_line_buffer (
    .clk       (clk),
    .rst       (rst),
    .ld_line_i (ld_line),
    .line_i    (line_i),
    .ld_beat_i (ld_beat),
    .wr_idx_i  (cnt_q),
    .beat_i    (burst_i),
    .rd_idx_i  (cnt_q + 1'b1),
    .beat_o    (buf_beat),
    .line_o    (buf_line)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    burst_d = burst_q;
    fill_d  = fill_q;
    ld_line = 1'b0;
    ld_beat = 1'b0;
`ifdef CLA_TIMEOUT_EN
    wdog_d  = '0;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (write_i) begin
          state_d = WR_BURST;
          addr_d  = address_i & ADDR_MASK;
          ld_line = 1'b1;
          burst_d = line_i[burst_width-1:0];
        end else if (read_i) begin
          state_d = RD_BURST;
          addr_d  = address_i & ADDR_MASK;
        end
      end
      RD_BURST: begin
        if (resp_i) begin
          ld_beat = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            // final beat goes straight into the visible line alongside the buffered ones
            fill_d  = {burst_i, buf_line[LINE_WIDTH-burst_width-1:0]};
            state_d = RESP;
          end
        end
      end
      WR_BURST: begin
        if (resp_i) begin
          cnt_d   = cnt_q + 1'b1;
          burst_d = buf_beat;
          if (cnt_q == LAST_BEAT) state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef CLA_TIMEOUT_EN
    if ((state_q == RD_BURST || state_q == WR_BURST) && !resp_i) begin
      if (wdog_q == TIMEOUT_MAX - 8'd1) begin
        state_d = RESP;
        cnt_d   = '0;
        err_d   = 1'b1;
      end else begin
        wdog_d = wdog_q + 8'd1;
      end
    end
`endif
    if (state_d != RD_BURST && state_d != WR_BURST) addr_d = '0;
    if (state_d != WR_BURST) burst_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      burst_q <= '0;
      fill_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      burst_q <= burst_d;
      fill_q  <= fill_d;
      read_q  <= (state_d == RD_BURST);
      write_q <= (state_d == WR_BURST);
      resp_q  <= (state_d == RESP);
    end
  end

`ifdef CLA_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign line_o    = fill_q;
  assign resp_o    = resp_q;
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign burst_o   = burst_q;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Directed self-checking bench for cacheline_burst_adapter; inputs driven and
// outputs sampled on the falling edge. Watchdog case runs when CLA_TIMEOUT_EN is defined.
module tb_cacheline_burst_adapter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  address_i = '0;
  logic         read_i = 1'b0;
  logic         write_i = 1'b0;
  logic [255:0] line_i = '0;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i = '0;
  logic         resp_i = 1'b0;
  logic         err_o;

  int total = 0;
  int bad   = 0;

  cacheline_burst_adapter dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [63:0] rep(input logic [7:0] b);
    return {8{b}};
  endfunction

  // Accept in the current cycle, four back-to-back beats, completion checks at N+5.
  task automatic run_read(input string tag, input logic [31:0] addr, input logic [255:0] ln);
    address_i = addr;
    read_i    = 1'b1;
    cyc();
    read_i = 1'b0;
    check_val({tag, "_addr"}, address_o, {addr[31:5], 5'b0});
    for (int k = 0; k < 4; k++) begin
      check_val({tag, "_read_o"}, read_o, 1'b1);
      check_val({tag, "_no_resp"}, resp_o, 1'b0);
      resp_i  = 1'b1;
      burst_i = ln[64*k +: 64];
      cyc();
    end
    resp_i  = 1'b0;
    burst_i = '0;
    check_val({tag, "_resp"}, resp_o, 1'b1);
    check_val({tag, "_read_drop"}, read_o, 1'b0);
    check_val({tag, "_line"}, line_o, ln);
    cyc();
    check_val({tag, "_resp_once"}, resp_o, 1'b0);
    check_val({tag, "_addr_idle"}, address_o, 32'h0);
  endtask

  logic [255:0] l1, wl, gl, rl;
  logic [63:0]  gd [4];
  logic [6:0]   pat;
  int           bi, pulses, rd_bad;

  initial begin
    l1 = {rep(8'h44), rep(8'h33), rep(8'h22), rep(8'h11)};
    wl = {64'hDEAD_0000_0000_BEE3, 64'hDEAD_0000_0000_BEE2,
          64'hDEAD_0000_0000_BEE1, 64'hDEAD_0000_0000_BEE0};
    gd[0] = rep(8'hA1); gd[1] = rep(8'hB2); gd[2] = rep(8'hC3); gd[3] = rep(8'hD4);
    gl = {gd[3], gd[2], gd[1], gd[0]};
    rl = {rep(8'h84), rep(8'h83), rep(8'h82), rep(8'h81)};
    pat = 7'b1011001;  // sequence 1,0,0,1,1,0,1 read from bit 0 upward

    // reset state
    cyc();
    check_val("rst_resp", resp_o, 1'b0);
    check_val("rst_read", read_o, 1'b0);
    check_val("rst_write", write_o, 1'b0);
    check_val("rst_addr", address_o, 32'h0);
    check_val("rst_line", line_o, 256'h0);
    check_val("rst_err", err_o, 1'b0);
    rst = 1'b0;
    cyc();

    // basic fill
    run_read("rd1", 32'h0000_1234, l1);

    // writeback with one gap between beats 1 and 2
    address_i = 32'h0000_ABCD;
    line_i    = wl;
    write_i   = 1'b1;
    cyc();
    write_i = 1'b0;
    check_val("wr_write_o", write_o, 1'b1);
    check_val("wr_read_o", read_o, 1'b0);
    check_val("wr_addr", address_o, 32'h0000_ABC0);
    check_val("wr_beat0", burst_o, wl[63:0]);
    resp_i = 1'b1;
    cyc();
    check_val("wr_beat1", burst_o, wl[127:64]);
    resp_i = 1'b0;
    cyc();
    check_val("wr_beat1_hold", burst_o, wl[127:64]);
    resp_i = 1'b1;
    cyc();
    check_val("wr_beat2", burst_o, wl[191:128]);
    cyc();
    check_val("wr_beat3", burst_o, wl[255:192]);
    check_val("wr_write_hold", write_o, 1'b1);
    cyc();
    resp_i = 1'b0;
    check_val("wr_write_drop", write_o, 1'b0);
    check_val("wr_resp", resp_o, 1'b1);
    check_val("wr_line_kept", line_o, l1);
    cyc();
    check_val("wr_resp_once", resp_o, 1'b0);

    // simultaneous request: write wins, held read follows with gapped beats
    address_i = 32'h0000_2000;
    line_i    = ~wl;
    write_i   = 1'b1;
    read_i    = 1'b1;
    cyc();
    write_i = 1'b0;
    check_val("both_write_o", write_o, 1'b1);
    check_val("both_read_o", read_o, 1'b0);
    for (int k = 0; k < 4; k++) begin
      resp_i = 1'b1;
      cyc();
    end
    resp_i = 1'b0;
    check_val("both_resp", resp_o, 1'b1);
    check_val("both_no_read_in_resp", read_o, 1'b0);
    cyc();
    check_val("both_idle_read_o", read_o, 1'b0);
    check_val("both_idle_resp_o", resp_o, 1'b0);
    bi = 0; pulses = 0; rd_bad = 0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      if (read_o !== 1'b1) rd_bad++;
      if (resp_o === 1'b1) pulses++;
      read_i  = 1'b0;
      resp_i  = pat[i];
      burst_i = pat[i] ? gd[bi] : rep(8'hEE);
      if (pat[i]) bi++;
    end
    cyc();
    resp_i  = 1'b0;
    burst_i = '0;
    check_val("gap_read_held", rd_bad, 0);
    check_val("gap_resp", resp_o, 1'b1);
    check_val("gap_read_drop", read_o, 1'b0);
    check_val("gap_line", line_o, gl);
    if (resp_o === 1'b1) pulses++;
    cyc();
    if (resp_o === 1'b1) pulses++;
    check_val("gap_resp_count", pulses, 1);

    // reset after beat 2 of a read, then a clean fill
    address_i = 32'h0000_0040;
    read_i    = 1'b1;
    cyc();
    read_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      resp_i  = 1'b1;
      burst_i = rep(8'h55 + 8'(k));
      cyc();
    end
    resp_i = 1'b0;
    rst    = 1'b1;
    cyc();
    check_val("mid_rst_read", read_o, 1'b0);
    check_val("mid_rst_resp", resp_o, 1'b0);
    check_val("mid_rst_addr", address_o, 32'h0);
    check_val("mid_rst_line", line_o, 256'h0);
    check_val("mid_rst_err", err_o, 1'b0);
    rst = 1'b0;
    run_read("rd2", 32'h0000_009F, rl);

    // a stray acknowledge while idle must not start or disturb anything
    resp_i = 1'b1;
    cyc();
    resp_i = 1'b0;
    cyc();
    check_val("idle_resp_ignored", resp_o, 1'b0);
    check_val("idle_line_kept", line_o, rl);

`ifdef CLA_TIMEOUT_EN
    address_i = 32'h0000_3000;
    read_i    = 1'b1;
    cyc();
    read_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 254; i++) begin
      if (resp_o === 1'b1) pulses++;
      cyc();
    end
    check_val("to_no_early_resp", pulses, 0);
    check_val("to_no_early_err", err_o, 1'b0);
    cyc();
    check_val("to_resp", resp_o, 1'b1);
    check_val("to_err", err_o, 1'b1);
    check_val("to_line_kept", line_o, rl);
    cyc();
    cyc();
    check_val("to_err_sticky", err_o, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_val("to_err_cleared", err_o, 1'b0);
`else
    check_val("err_tied_low", err_o, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
